uart_tx_feeder: RTL and testbench
=================================

# uart_tx_feeder

Byte-buffered transmit front end for the UART peripheral. The CPU-side bus logic writes bytes into an internal FIFO. A launch FSM drains the FIFO one byte at a time into the UART sender's `UART_TXD`/`TX_EN`/`TX_STATUS` handshake, so software no longer polls `TX_STATUS` per byte. The block sits between the peripheral register decoder and the UART's transmit port.

## Interface
- `DEPTH`, 16: FIFO entries; power of two, at least 2.
- `AW`, $clog2(DEPTH): pointer width (derived).
- `LAUNCH_TIMEOUT`, 4096: sysclk cycles to wait for `TX_STATUS` to drop after `TX_EN` rises.

- `sysclk`  in  1  system clock; single clock domain.
- `reset`  in  1  asynchronous, active-low reset.
- `wr_en`  in  1  push `wr_data` this cycle.
- `wr_data`  in  8  byte to transmit.
- `clr_err`  in  1  clears `overflow` and `timeout_err`.
- `TX_STATUS`  in  1  from UART sender; 1 = idle/ready.
- `UART_TXD`  out  8  byte presented to the sender.
- `TX_EN`  out  1  start request to the sender.
- `fifo_full`  out  1  FIFO holds DEPTH entries.
- `fifo_empty`  out  1  FIFO holds 0 entries.
- `fifo_count`  out  AW+1  current occupancy.
- `busy`  out  1  FSM not in IDLE, or FIFO non-empty.
- `overflow`  out  1  sticky flag: a write was dropped because the FIFO was full.
- `timeout_err`  out  1  sticky flag: a launch timed out.

## Operation
- FIFO pointers are AW+1 bits wide with a wrap bit.
  - `fifo_full` = MSBs differ and low bits equal.
  - `fifo_empty` = pointers equal.
  - `fifo_count` = wr_ptr − rd_ptr, modulo 2^(AW+1).
- Write with `fifo_full`=1: data is dropped, pointer unchanged, `overflow` set. Full is judged on the registered state, so the write is rejected even if a pop occurs in the same cycle.
- FSM states:
  - IDLE: if `fifo_empty`=0 and `TX_STATUS`=1, pop the head into the `UART_TXD` register, set `TX_EN`=1, clear the timer, go to LAUNCH.
  - LAUNCH: hold `TX_EN`=1 and `UART_TXD` stable. On `TX_STATUS`=0, drop `TX_EN` and go to WAIT_DONE. If the timer reaches LAUNCH_TIMEOUT−1, drop `TX_EN`, set `timeout_err`, discard the byte and go to IDLE.
  - WAIT_DONE: `TX_EN`=0. On `TX_STATUS`=1, go to IDLE.
- `UART_TXD` keeps its last launched value outside LAUNCH.
- `clr_err` and a same-cycle set of either flag: the set wins.
- Simultaneous push and pop with FIFO neither full nor empty: both take effect; count is unchanged.
- Reset asserted mid-operation: FIFO contents are abandoned and the FSM returns to IDLE immediately. A byte already handed to the sender is not recalled.

## Timing
- Reset values: `UART_TXD`=0x00, `TX_EN`=0, `fifo_full`=0, `fifo_empty`=1, `fifo_count`=0, `busy`=0, `overflow`=0, `timeout_err`=0. FSM=IDLE, pointers=0, timer=0.
- Write to an empty FIFO with the sender idle:
  - Edge N accepts the write; `fifo_empty`=0 after N.
  - After edge N+1, `TX_EN`=1 and `UART_TXD` = the byte, and `fifo_count` is back to 0.
- `TX_EN` drops on the first edge that samples `TX_STATUS`=0.
- Next launch comes no earlier than one edge after `TX_STATUS` returns to 1. Back-to-back bytes therefore cost the sender frame time plus 2 sysclk.
- All outputs are registered except `fifo_full`, `fifo_empty`, `fifo_count` and `busy`, which are combinational decodes of registers.

## Structure
- Package `uart_pkg`:
  - FSM state enum `tx_feed_state_t` {IDLE, LAUNCH, WAIT_DONE}.
  - Byte width constant `UART_DW`=8.
  - Default `LAUNCH_TIMEOUT`.
- Sub-module `sync_fifo` (parameters DEPTH and width):
  - Register-array storage, pointers, flags and count.
  - Exposes push/pop/head.
  - Reused later for the RX path.
- `uart_tx_feeder` holds the FSM, timer, sticky flags and the output register.

## Test plan
- Reset, then write 0x55 with `TX_STATUS`=1 → `TX_EN` high 1 cycle after the write edge with `UART_TXD`=0x55. Drive `TX_STATUS` low 3 cycles later → `TX_EN` low on the next edge.
- Write 0x01..0x03 back-to-back, sender model busy 20 cycles per byte → the sender receives exactly 0x01, 0x02, 0x03 in order; `fifo_count` steps 3→2→1→0; `busy` falls after the final `TX_STATUS` rise.
- Fill 16 entries with `TX_STATUS` held 0, then write 0xAA → `fifo_full`=1, `overflow`=1, count stays 16, 0xAA never transmitted. Pulse `clr_err` → `overflow`=0.
- Load one byte, hold `TX_STATUS`=1 (sender never acknowledges) → after 4096 cycles `TX_EN`=0, `timeout_err`=1, FIFO empty, FSM in IDLE.
- Assert `reset` during LAUNCH with 5 bytes queued → outputs immediately at their reset values; after release no `TX_EN` without a new write.
- With count=15 and one pop in flight, write in the same cycle as the pop → accepted, count stays 15. With count=16, a write in the same cycle as a pop is rejected and `overflow` is set.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: data width, default launch timeout and the
// transmit feeder FSM encoding.
package uart_pkg;

    localparam int UART_DW             = 8;
    localparam int DEF_LAUNCH_TIMEOUT  = 4096;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LAUNCH    = 2'd1,
        WAIT_DONE = 2'd2
    } tx_feed_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with wrap-bit pointers; head is the oldest entry and is
// valid whenever empty is low.
module sync_fifo #(
    parameter  int DEPTH = 16,
    parameter  int WIDTH = 8,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             sysclk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty   = (wr_ptr == rd_ptr);
    assign count   = wr_ptr - rd_ptr;
    assign head    = mem[rd_ptr[AW-1:0]];

    // Full/empty come from registered pointers, so a push against a full
    // FIFO is refused even if a pop lands in the same cycle.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge sysclk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/uart_tx_feeder.sv
// Drains a byte FIFO into the UART sender's TX_EN/TX_STATUS handshake, one
// launch at a time, with a timeout on the sender's acknowledge.
module uart_tx_feeder
    import uart_pkg::*;
#(
    parameter  int DEPTH          = 16,
    parameter  int LAUNCH_TIMEOUT = DEF_LAUNCH_TIMEOUT,
    localparam int AW             = $clog2(DEPTH)
) (
    input  logic               sysclk,
    input  logic               reset,
    input  logic               wr_en,
    input  logic [UART_DW-1:0] wr_data,
    input  logic               clr_err,
    input  logic               TX_STATUS,
    output logic [UART_DW-1:0] UART_TXD,
    output logic               TX_EN,
    output logic               fifo_full,
    output logic               fifo_empty,
    output logic [AW:0]        fifo_count,
    output logic               busy,
    output logic               overflow,
    output logic               timeout_err
);

    localparam int            TW         = $clog2(LAUNCH_TIMEOUT);
    localparam logic [TW-1:0] TIMER_LAST = TW'(LAUNCH_TIMEOUT - 1);

    tx_feed_state_t     state;
    logic [TW-1:0]      timer;
    logic [UART_DW-1:0] head;
    logic               pop;
    logic               launch_to;

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (UART_DW)
    ) u_fifo (
        .sysclk    (sysclk),
        .reset     (reset),
        .push      (wr_en),
        .push_data (wr_data),
        .pop       (pop),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign pop       = (state == IDLE) && !fifo_empty && TX_STATUS;
    assign launch_to = (state == LAUNCH) && TX_STATUS && (timer == TIMER_LAST);
    assign busy      = (state != IDLE) || !fifo_empty;

    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            TX_EN    <= 1'b0;
            UART_TXD <= '0;
            timer    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        UART_TXD <= head;
                        TX_EN    <= 1'b1;
                        timer    <= '0;
                        state    <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    // Sender acknowledge beats a coincident timeout.
                    if (!TX_STATUS) begin
                        TX_EN <= 1'b0;
                        state <= WAIT_DONE;
                    end else if (timer == TIMER_LAST) begin
                        TX_EN <= 1'b0;
                        state <= IDLE;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                WAIT_DONE: begin
                    if (TX_STATUS) state <= IDLE;
                end
                default: begin
                    TX_EN <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    // Sticky error flags; a set in the same cycle as clr_err wins.
    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            overflow    <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            if (wr_en && fifo_full) overflow <= 1'b1;
            else if (clr_err)       overflow <= 1'b0;
            if (launch_to)          timeout_err <= 1'b1;
            else if (clr_err)       timeout_err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Scoreboard bench: stimulus queues accepted bytes, a monitor checks launches,
// handshake timing, occupancy and flags against a queue-level model.
module tb_uart_tx_feeder;

    localparam int DEPTH = 16;
    localparam int LT    = 4096;

    logic       sysclk;
    logic       reset;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       clr_err;
    logic       TX_STATUS;
    logic [7:0] UART_TXD;
    logic       TX_EN;
    logic       fifo_full;
    logic       fifo_empty;
    logic [4:0] fifo_count;
    logic       busy;
    logic       overflow;
    logic       timeout_err;

    uart_tx_feeder dut (
        .sysclk      (sysclk),
        .reset       (reset),
        .wr_en       (wr_en),
        .wr_data     (wr_data),
        .clr_err     (clr_err),
        .TX_STATUS   (TX_STATUS),
        .UART_TXD    (UART_TXD),
        .TX_EN       (TX_EN),
        .fifo_full   (fifo_full),
        .fifo_empty  (fifo_empty),
        .fifo_count  (fifo_count),
        .busy        (busy),
        .overflow    (overflow),
        .timeout_err (timeout_err)
    );

    initial sysclk = 1'b0;
    always #5 sysclk = ~sysclk;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [7:0] exp_q[$];
    bit         in_flight, acked, exp_ovf, exp_to, ovf_pending;
    int         hi_cnt;
    logic       prev_en;
    logic [7:0] prev_txd;

    // Sender model controls
    bit         ack_en, snd_status, hold_status;
    int         lat_lo, lat_hi, frm_lo, frm_hi;

    always_comb TX_STATUS = ack_en ? snd_status : hold_status;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, req, $time);
        end
    endtask

    task automatic cyc(input logic we, input logic [7:0] d, input logic clr);
        @(negedge sysclk);
        #2;
        wr_en   = we;
        wr_data = d;
        clr_err = clr;
        if (we) begin
            if (exp_q.size() < DEPTH) exp_q.push_back(d);
            else                      ovf_pending = 1'b1;
        end
    endtask

    task automatic reset_chk();
        chk("rst_txd",   UART_TXD, 0);
        chk("rst_tx_en", TX_EN, 0);
        chk("rst_full",  fifo_full, 0);
        chk("rst_empty", fifo_empty, 1);
        chk("rst_count", fifo_count, 0);
        chk("rst_busy",  busy, 0);
        chk("rst_ovf",   overflow, 0);
        chk("rst_to",    timeout_err, 0);
    endtask

    task automatic do_reset();
        @(negedge sysclk);
        #2;
        reset   = 1'b0;
        wr_en   = 1'b0;
        clr_err = 1'b0;
        #1;
        exp_q.delete();
        in_flight   = 0;
        acked       = 0;
        exp_ovf     = 0;
        exp_to      = 0;
        ovf_pending = 0;
        reset_chk();
        repeat (2) @(negedge sysclk);
        #2 reset = 1'b1;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || in_flight) && n < budget) begin
            cyc(0, 8'h00, 0);
            n++;
        end
        chk("drain_in_budget", 32'(exp_q.size() == 0 && !in_flight), 1);
    endtask

    // Sender: after seeing TX_EN, drops TX_STATUS after a latency, holds it
    // low for a frame, then reports idle again.
    initial begin
        int unsigned n;
        snd_status = 1'b1;
        forever begin
            @(negedge sysclk);
            #2;
            if (ack_en && reset && TX_EN && snd_status) begin
                n = $urandom_range(lat_hi, lat_lo);
                repeat (n) begin @(negedge sysclk); #2; end
                snd_status = 1'b0;
                n = $urandom_range(frm_hi, frm_lo);
                repeat (n) begin @(negedge sysclk); #2; end
                snd_status = 1'b1;
            end
        end
    end

    // Monitor: inputs and TX_STATUS read here are the values the last edge sampled.
    initial begin
        bit         launch, tout;
        logic [7:0] b;
        forever begin
            @(negedge sysclk);
            if (!reset) begin
                prev_en  = 1'b0;
                prev_txd = 8'h00;
                continue;
            end
            launch = TX_EN && !prev_en;
            tout   = 0;
            if (in_flight && acked && TX_STATUS) in_flight = 0;
            if (in_flight && !acked && prev_en) begin
                if (!TX_STATUS) begin
                    chk("tx_en_drop", TX_EN, 0);
                    acked = 1;
                end else if (hi_cnt == LT) begin
                    chk("timeout_drop", TX_EN, 0);
                    in_flight = 0;
                    tout      = 1;
                end else begin
                    chk("tx_en_hold", TX_EN, 1);
                    hi_cnt++;
                end
            end
            if (launch) begin
                chk("launch_sender_idle", TX_STATUS, 1);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_launch actual=%0h required=no_launch t=%0t", UART_TXD, $time);
                end else begin
                    b = exp_q.pop_front();
                    chk("txd_byte", UART_TXD, b);
                end
                in_flight = 1;
                acked     = 0;
                hi_cnt    = 1;
            end else begin
                chk("txd_stable", UART_TXD, prev_txd);
            end
            if (ovf_pending) begin
                exp_ovf     = 1;
                ovf_pending = 0;
            end else if (clr_err) exp_ovf = 0;
            if (tout)         exp_to = 1;
            else if (clr_err) exp_to = 0;
            chk("count", fifo_count, 32'(exp_q.size()));
            chk("empty", fifo_empty, 32'(exp_q.size() == 0));
            chk("full",  fifo_full,  32'(exp_q.size() == DEPTH));
            chk("busy",  busy, 32'(exp_q.size() != 0 || in_flight));
            chk("overflow",    overflow, 32'(exp_ovf));
            chk("timeout_err", timeout_err, 32'(exp_to));
            prev_en  = TX_EN;
            prev_txd = UART_TXD;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b0; wr_en = 1'b0; wr_data = 8'h00; clr_err = 1'b0;
        ack_en = 1'b1; hold_status = 1'b1;
        lat_lo = 3; lat_hi = 3; frm_lo = 20; frm_hi = 20;
        in_flight = 0; acked = 0; exp_ovf = 0; exp_to = 0; ovf_pending = 0; hi_cnt = 0;
        prev_en = 1'b0; prev_txd = 8'h00;
        repeat (2) @(negedge sysclk);
        reset_chk();
        #2 reset = 1'b1;

        // Single byte: launch one edge after the write edge
        cyc(1, 8'h55, 0);
        cyc(0, 8'h00, 0);
        chk("t1_not_empty", fifo_empty, 0);
        chk("t1_no_en_yet", TX_EN, 0);
        cyc(0, 8'h00, 0);
        chk("t1_tx_en", TX_EN, 1);
        chk("t1_txd", UART_TXD, 8'h55);
        chk("t1_count", fifo_count, 0);
        wait_idle(100);

        // Back-to-back bytes, 20-cycle frames
        lat_lo = 0; lat_hi = 3;
        cyc(1, 8'h01, 0);
        cyc(1, 8'h02, 0);
        cyc(1, 8'h03, 0);
        wait_idle(200);
        chk("t2_busy_done", busy, 0);

        // Fill with sender busy, then overflow
        ack_en = 1'b0; hold_status = 1'b0;
        for (int i = 0; i < DEPTH; i++) cyc(1, 8'(8'h10 + i), 0);
        cyc(1, 8'hAA, 0);
        cyc(0, 8'h00, 0);
        chk("t3_full", fifo_full, 1);
        chk("t3_ovf", overflow, 1);
        chk("t3_count", fifo_count, 16);
        cyc(0, 8'h00, 1);
        cyc(0, 8'h00, 0);
        chk("t3_ovf_clr", overflow, 0);

        // Full with a pop in the same cycle: write still rejected
        cyc(1, 8'hAB, 0);
        hold_status = 1'b1;
        cyc(0, 8'h00, 0);
        chk("t6_full_pop_count", fifo_count, 15);
        chk("t6_full_pop_ovf", overflow, 1);
        hold_status = 1'b0;
        cyc(0, 8'h00, 0);
        hold_status = 1'b1;
        cyc(0, 8'h00, 0);
        // count 15 with a pop in flight: write accepted, count unchanged
        cyc(1, 8'hC3, 0);
        cyc(0, 8'h00, 1);
        chk("t6_15_pop_count", fifo_count, 15);
        snd_status = 1'b1;
        ack_en = 1'b1;
        wait_idle(2000);

        // Sender never acknowledges: launch times out
        ack_en = 1'b0; hold_status = 1'b1;
        cyc(1, 8'h5A, 0);
        wait_idle(LT + 50);
        chk("t4_to_flag", timeout_err, 1);
        chk("t4_tx_en", TX_EN, 0);
        chk("t4_empty", fifo_empty, 1);
        chk("t4_busy", busy, 0);
        cyc(0, 8'h00, 1);
        cyc(0, 8'h00, 0);
        chk("t4_to_clr", timeout_err, 0);

        // Reset mid-launch with 5 bytes queued
        for (int i = 0; i < 6; i++) cyc(1, 8'(8'h60 + i), 0);
        cyc(0, 8'h00, 0);
        chk("t5_count", fifo_count, 5);
        chk("t5_in_launch", TX_EN, 1);
        do_reset();
        repeat (30) cyc(0, 8'h00, 0);
        chk("t5_no_launch", TX_EN, 0);

        // Randomised traffic against the model
        ack_en = 1'b1; lat_lo = 0; lat_hi = 3; frm_lo = 1; frm_hi = 6;
        for (int i = 0; i < 1500; i++)
            cyc(($urandom_range(2, 0) == 0), 8'($urandom), ($urandom_range(29, 0) == 0));
        cyc(0, 8'h00, 0);
        wait_idle(4000);
        cyc(0, 8'h00, 1);
        cyc(0, 8'h00, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
